// File: rtl/video_timing_pkg.sv
// Shared types, 720p60 default timing and the phase decode used by both
// raster axes of the video timing generator.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    localparam int unsigned H_ACTIVE_720P = 1280;
    localparam int unsigned H_FP_720P     = 110;
    localparam int unsigned H_SYNC_720P   = 40;
    localparam int unsigned H_BP_720P     = 220;
    localparam int unsigned V_ACTIVE_720P = 720;
    localparam int unsigned V_FP_720P     = 5;
    localparam int unsigned V_SYNC_720P   = 5;
    localparam int unsigned V_BP_720P     = 20;
    localparam int unsigned CNT_BITS_720P = 12;

    // Sums are formed at 32 bits so the porch boundaries never truncate.
    function automatic phase_e axis_phase(input int unsigned count,
                                          input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
        phase_e ph;
        if (count < active)
            ph = PH_ACTIVE;
        else if (count < active + fp)
            ph = PH_FRONT;
        else if (count < active + fp + sync)
            ph = PH_SYNC;
        else
            ph = PH_BACK;
        return ph;
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping position counter with its timing phase and an
// end-of-axis strobe that cascades into the next (slower) axis.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE   = H_ACTIVE_720P,
    parameter int unsigned FP       = H_FP_720P,
    parameter int unsigned SYNC     = H_SYNC_720P,
    parameter int unsigned BP       = H_BP_720P,
    parameter int unsigned CNT_BITS = CNT_BITS_720P
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count,
    output phase_e              phase,
    output logic                wrap
);

    localparam int unsigned         TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_BITS-1:0] LAST  = CNT_BITS'(TOTAL - 1);

    assign wrap = inc && (count == LAST);

    always_comb begin
        phase = axis_phase(32'(count), ACTIVE, FP, SYNC, BP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running progressive raster timing generator: registered sync, DE,
// coordinates and frame/line pulses, all aligned one clock after the counters.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
    parameter int unsigned H_FP     = H_FP_720P,
    parameter int unsigned H_SYNC   = H_SYNC_720P,
    parameter int unsigned H_BP     = H_BP_720P,
    parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
    parameter int unsigned V_FP     = V_FP_720P,
    parameter int unsigned V_SYNC   = V_SYNC_720P,
    parameter int unsigned V_BP     = V_BP_720P,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned CNT_BITS = CNT_BITS_720P
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic                o_de,
    output logic [CNT_BITS-1:0] o_x,
    output logic [CNT_BITS-1:0] o_y,
    output logic                o_sof,
    output logic                o_eol
);

    localparam logic [CNT_BITS-1:0] H_LAST_ACTIVE = CNT_BITS'(H_ACTIVE - 1);

    logic [CNT_BITS-1:0] h_cnt;
    logic [CNT_BITS-1:0] v_cnt;
    phase_e              h_phase;
    phase_e              v_phase;
    logic                h_wrap;
    logic                unused_v_wrap;

    timing_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .CNT_BITS (CNT_BITS)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~i_en),
        .inc   (i_en),
        .count (h_cnt),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    timing_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .CNT_BITS (CNT_BITS)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~i_en),
        .inc   (h_wrap),
        .count (v_cnt),
        .phase (v_phase),
        .wrap  (unused_v_wrap)
    );

    logic                hsync_d, vsync_d, de_d, sof_d, eol_d;
    logic [CNT_BITS-1:0] x_d, y_d;

    // Dropping i_en drives the idle (reset) values on the same edge the
    // counters clear, so a restart always begins with a clean frame.
    always_comb begin
        hsync_d = ~HS_POL;
        vsync_d = ~VS_POL;
        de_d    = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        x_d     = '0;
        y_d     = '0;
        if (i_en) begin
            hsync_d = (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_d = (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            de_d    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            sof_d   = (h_cnt == '0) && (v_cnt == '0);
            eol_d   = (h_cnt == H_LAST_ACTIVE) && (v_phase == PH_ACTIVE);
            x_d     = h_cnt;
            y_d     = v_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hsync <= ~HS_POL;
            o_vsync <= ~VS_POL;
            o_de    <= 1'b0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
        end else begin
            o_hsync <= hsync_d;
            o_vsync <= vsync_d;
            o_de    <= de_d;
            o_sof   <= sof_d;
            o_eol   <= eol_d;
            o_x     <= x_d;
            o_y     <= y_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in an 8x6 raster, with an active-high and an
// active-low sync instance driven side by side against a raster-position model.
module tb_video_timing_gen;

    localparam int H_TOT = 8;
    localparam int V_TOT = 6;
    localparam int F_TOT = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;

    logic        hs_p, vs_p, de_p, sof_p, eol_p;
    logic [11:0] x_p, y_p;
    logic        hs_n, vs_n, de_n, sof_n, eol_n;
    logic [11:0] x_n, y_n;

    int checks = 0;
    int errors = 0;
    int pos    = -1;
    int edge_no = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CNT_BITS (12)
    ) dut_pos (
        .clk (clk), .rst_n (rst_n), .i_en (i_en),
        .o_hsync (hs_p), .o_vsync (vs_p), .o_de (de_p),
        .o_x (x_p), .o_y (y_p), .o_sof (sof_p), .o_eol (eol_p)
    );

    video_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0), .CNT_BITS (12)
    ) dut_neg (
        .clk (clk), .rst_n (rst_n), .i_en (i_en),
        .o_hsync (hs_n), .o_vsync (vs_n), .o_de (de_n),
        .o_x (x_n), .o_y (y_n), .o_sof (sof_n), .o_eol (eol_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Raster position pos counts clocks since frame start; -1 is idle.
    task automatic check_model(input string tag);
        int x, y;
        logic e_de, e_hs, e_vs, e_sof, e_eol;
        if (pos < 0) begin
            x = 0; y = 0;
            e_de = 0; e_hs = 0; e_vs = 0; e_sof = 0; e_eol = 0;
        end else begin
            x = pos % H_TOT;
            y = pos / H_TOT;
            e_de  = (x < 4) && (y < 3);
            e_hs  = (x >= 5) && (x < 7);
            e_vs  = (y == 4);
            e_sof = (pos == 0);
            e_eol = (x == 3) && (y < 3);
        end
        check({tag, ".x"},     32'(x_p),   32'(x));
        check({tag, ".y"},     32'(y_p),   32'(y));
        check({tag, ".de"},    32'(de_p),  32'(e_de));
        check({tag, ".hsync"}, 32'(hs_p),  32'(e_hs));
        check({tag, ".vsync"}, 32'(vs_p),  32'(e_vs));
        check({tag, ".sof"},   32'(sof_p), 32'(e_sof));
        check({tag, ".eol"},   32'(eol_p), 32'(e_eol));
        check({tag, ".hsync_n"}, 32'(hs_n), 32'(!e_hs));
        check({tag, ".vsync_n"}, 32'(vs_n), 32'(!e_vs));
        check({tag, ".de_n"},    32'(de_n), 32'(e_de));
        check({tag, ".xy_n"},    {x_n[11:0], 4'h0, y_n[11:0], 4'h0}, {12'(x), 4'h0, 12'(y), 4'h0});
    endtask

    task automatic tick();
        @(posedge clk);
        if (i_en) pos = (pos + 1) % F_TOT;
        else      pos = -1;
        edge_no++;
        @(negedge clk);
    endtask

    logic [16:1] de_v, hs_v, eol_v;
    int sof_cnt, sof_first, sof_second, vs_cnt, de_cnt;

    initial begin
        rst_n = 1'b0;
        i_en  = 1'b0;
        repeat (3) @(negedge clk);
        check_model("reset");

        // Directed: two full frames from reset release.
        rst_n = 1'b1;
        i_en  = 1'b1;
        edge_no = 0;
        de_v = '0; hs_v = '0; eol_v = '0;
        sof_cnt = 0; sof_first = 0; sof_second = 0; vs_cnt = 0; de_cnt = 0;
        repeat (2 * F_TOT) begin
            tick();
            check_model("frame");
            if (edge_no <= 16) begin
                de_v[edge_no]  = de_p;
                hs_v[edge_no]  = hs_p;
                eol_v[edge_no] = eol_p;
            end
            if (sof_p) begin
                sof_cnt++;
                if (sof_cnt == 1) sof_first = edge_no;
                if (sof_cnt == 2) sof_second = edge_no;
            end
            if (vs_p) vs_cnt++;
            if (de_p) de_cnt++;
        end
        check("line.de_mask",   32'(de_v),  32'h0F0F);
        check("line.hs_mask",   32'(hs_v),  32'h6060);
        check("line.eol_mask",  32'(eol_v), 32'h0808);
        check("frame.sof_cnt",  32'(sof_cnt),    32'd2);
        check("frame.sof_1st",  32'(sof_first),  32'd1);
        check("frame.sof_2nd",  32'(sof_second), 32'd49);
        check("frame.vs_cnt",   32'(vs_cnt),     32'd16);
        check("frame.de_cnt",   32'(de_cnt),     32'd24);

        // Enable drop at the edge that would report (x=3, y=2).
        i_en = 1'b0; rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; pos = -1;
        i_en = 1'b1;
        repeat (19) begin tick(); check_model("endrop.pre"); end
        i_en = 1'b0;
        repeat (3) begin tick(); check_model("endrop.off"); end
        i_en = 1'b1;
        tick();
        check_model("endrop.restart");
        check("endrop.sof", 32'(sof_p), 32'd1);

        // Async reset mid-line while x=2.
        while (!(pos >= 0 && (pos % H_TOT) == 2)) begin tick(); check_model("areset.pre"); end
        check("areset.x_before", 32'(x_p), 32'd2);
        rst_n = 1'b0;
        pos = -1;
        #1;
        check_model("areset.immediate");
        #1 rst_n = 1'b1;
        tick();
        check_model("areset.restart");
        check("areset.sof", 32'(sof_p), 32'd1);

        // Randomized enable drops and asynchronous reset pulses.
        repeat (3000) begin
            i_en = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                pos = -1;
                #1;
                check_model("rand.areset");
                #1 rst_n = 1'b1;
            end
            tick();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running raster timing generator for the HDMI output path.
- Produces hsync, vsync, data-enable and pixel coordinates for one progressive video mode.
- Its outputs feed the pixel-fetch/colour pipeline. They also feed the fixed-latency sync delay line that realigns sync/DE with the processed pixel data before the TMDS encoders.
- Everything runs in the pixel-clock domain.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- CNT_BITS, 12, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- i_en, input, 1, run enable; low = hold at frame start
- o_hsync, output, 1, horizontal sync at HS_POL level
- o_vsync, output, 1, vertical sync at VS_POL level
- o_de, output, 1, active-video data enable
- o_x, output, CNT_BITS, horizontal counter (valid as pixel column when o_de=1)
- o_y, output, CNT_BITS, vertical counter (valid as pixel row when o_de=1)
- o_sof, output, 1, one-clock pulse on first active pixel of a frame
- o_eol, output, 1, one-clock pulse on last active pixel of each active line

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters h_cnt range 0..H_TOTAL-1 and v_cnt range 0..V_TOTAL-1.
- On each clk edge with i_en=1, outputs are registered from the current (h_cnt, v_cnt), then:
  - h_cnt advances; it wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps; it wraps V_TOTAL-1 -> 0 on the same edge.
- Latency: all outputs are registered, one clock after the counter value they describe. All outputs are mutually aligned, with no skew between sync, DE and coordinates.
- Horizontal phases, as h_cnt ranges:
  - ACTIVE [0, H_ACTIVE)
  - FRONT [H_ACTIVE, H_ACTIVE+H_FP)
  - SYNC [.., +H_SYNC)
  - BACK [.., H_TOTAL)
- Vertical phases use the same split over v_cnt. Vertical phases switch only at h_cnt=0, so vsync edges are line-aligned.
- Output equations:
  - o_de = h ACTIVE and v ACTIVE.
  - o_hsync = HS_POL during h SYNC, otherwise ~HS_POL.
  - o_vsync = VS_POL during v SYNC, otherwise ~VS_POL.
  - o_x = h_cnt; o_y = v_cnt.
  - o_sof = (h_cnt==0 && v_cnt==0).
  - o_eol = (h_cnt==H_ACTIVE-1 && v ACTIVE).
- Reset (rst_n low, asynchronous): h_cnt=v_cnt=0; o_de=0, o_sof=0, o_eol=0, o_x=0, o_y=0, o_hsync=~HS_POL, o_vsync=~VS_POL.
- First enabled edge after reset: o_de=1, o_sof=1, o_x=0, o_y=0.
- i_en=0 at a clk edge: synchronous return to the reset state (counters 0, outputs at reset values). This applies mid-line and mid-frame alike. On re-enable the generator starts a clean frame; partial frames are never resumed.
- Reset asserted mid-frame: immediate return to the reset state, same restart rule.
- Wrap boundaries:
  - Last clock of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) -> next edge reports (0,0) with o_sof=1.
  - No extra blank cycle at any wrap.
- Arithmetic is unsigned. Counter comparisons use CNT_BITS-wide constants; parameter sums must not be truncated.

Decomposition:
- Shared package video_timing_pkg holds:
  - phase enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}
  - 720p60 default constants
  - a function computing phase from (count, active, fp, sync, bp)
- Natural sub-module timing_axis_counter (parameters ACTIVE, FP, SYNC, BP, CNT_BITS):
  - inputs: clk, rst_n, clr, inc
  - outputs: count, phase, wrap
- Instantiated twice:
  - horizontal: inc=i_en
  - vertical: inc=h wrap
- The top level forms outputs and pulses and drives clr=~i_en.

Test Plan:
Small mode for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); 48 clocks/frame.
- Reset check: hold rst_n=0 -> o_de=0, o_hsync=0, o_vsync=0, o_x=0, o_y=0, o_sof=0.
- Line timing: release rst_n, i_en=1, 16 edges:
  - o_de high on edges 1-4 and 9-12 (x=0..3).
  - o_hsync high on edges 6-7 and 14-15.
  - o_eol high on edges 4 and 12.
- Frame timing: run 2 frames:
  - o_sof exactly at edges 1 and 49.
  - o_vsync high for the 8 edges where y=4.
  - o_de count = 12 per frame.
- Polarity: HS_POL=0, VS_POL=0 -> sync waveforms exactly inverted; o_de unchanged.
- Enable drop: i_en=0 at edge 20 (y=2, x=3) for 3 edges -> outputs at reset values. The edge after i_en returns to 1 reports x=0, y=0, o_sof=1.
- Async reset mid-line: pulse rst_n low between edges while x=2 -> outputs return to reset values immediately, without waiting for a clock. The next enabled edge reports frame start.
